// File: rtl/vedic_mult_if.sv
// Handshake bundle for vedic_mult_pipe: operand side (a/b/sgn/tag, valid/ready)
// and result side (p/tag, valid/ready).
interface vedic_mult_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             sgn;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   p;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, sgn, in_tag, out_ready,
    input  in_ready, out_valid, p, out_tag
  );

  modport slave (
    input  in_valid, a, b, sgn, in_tag, out_ready,
    output in_ready, out_valid, p, out_tag
  );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: half-width partial products, cross-term
// merge, then recombination with sign re-application. Fixed 3-cycle latency.
module vedic_mult_pipe #(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst,
  vedic_mult_if.slave bus
);
  localparam int H = W / 2;

  // -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [W-1:0] to_mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? (~x + W'(1)) : x;
  endfunction

  function automatic logic [W-1:0] half_mul(input logic [H-1:0] x, input logic [H-1:0] y);
    return W'(x) * W'(y);
  endfunction

  function automatic logic signed [2*W-1:0] apply_sign(input logic [2*W-1:0] mag,
                                                       input logic neg);
    logic signed [2*W-1:0] s;
    s = signed'(mag);
    return neg ? -s : s;
  endfunction

  logic en;

  logic [W-1:0]     a_mag, b_mag;
  logic [W-1:0]     ll_p0_d, lh_p0_d, hl_p0_d, hh_p0_d;
  logic [W-1:0]     ll_p0_q, lh_p0_q, hl_p0_q, hh_p0_q;
  logic             neg_p0_d, neg_p0_q, vld_p0_d, vld_p0_q;
  logic [TAG_W-1:0] tag_p0_d, tag_p0_q;

  logic [W:0]       mid_p1_d, mid_p1_q;
  logic [W-1:0]     ll_p1_d, ll_p1_q, hh_p1_d, hh_p1_q;
  logic             neg_p1_d, neg_p1_q, vld_p1_d, vld_p1_q;
  logic [TAG_W-1:0] tag_p1_d, tag_p1_q;

  logic [2*W-1:0]        mag_p2;
  logic signed [2*W-1:0] p_p2_d, p_p2_q;
  logic                  vld_p2_d, vld_p2_q;
  logic [TAG_W-1:0]      tag_p2_d, tag_p2_q;

  assign en           = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = en;

  // Stage 1: sign strip and four half-width partial products
  always_comb begin
    a_mag    = to_mag(bus.a, bus.sgn);
    b_mag    = to_mag(bus.b, bus.sgn);
    ll_p0_d  = half_mul(a_mag[H-1:0], b_mag[H-1:0]);
    lh_p0_d  = half_mul(a_mag[H-1:0], b_mag[W-1:H]);
    hl_p0_d  = half_mul(a_mag[W-1:H], b_mag[H-1:0]);
    hh_p0_d  = half_mul(a_mag[W-1:H], b_mag[W-1:H]);
    neg_p0_d = bus.sgn && (bus.a[W-1] ^ bus.b[W-1]);
    tag_p0_d = bus.in_tag;
    vld_p0_d = bus.in_valid && en;
  end

  // Stage 2: cross-term merge, carry kept
  always_comb begin
    mid_p1_d = {1'b0, lh_p0_q} + {1'b0, hl_p0_q};
    ll_p1_d  = ll_p0_q;
    hh_p1_d  = hh_p0_q;
    neg_p1_d = neg_p0_q;
    tag_p1_d = tag_p0_q;
    vld_p1_d = vld_p0_q;
  end

  // Stage 3: recombination and sign re-application
  always_comb begin
    mag_p2   = {hh_p1_q, {W{1'b0}}} + ((2*W)'(mid_p1_q) << H) + (2*W)'(ll_p1_q);
    p_p2_d   = apply_sign(mag_p2, neg_p1_q);
    tag_p2_d = tag_p1_q;
    vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ll_p0_q  <= '0;
      lh_p0_q  <= '0;
      hl_p0_q  <= '0;
      hh_p0_q  <= '0;
      neg_p0_q <= 1'b0;
      tag_p0_q <= '0;
      vld_p0_q <= 1'b0;
      mid_p1_q <= '0;
      ll_p1_q  <= '0;
      hh_p1_q  <= '0;
      neg_p1_q <= 1'b0;
      tag_p1_q <= '0;
      vld_p1_q <= 1'b0;
      p_p2_q   <= '0;
      tag_p2_q <= '0;
      vld_p2_q <= 1'b0;
    end else if (en) begin
      ll_p0_q  <= ll_p0_d;
      lh_p0_q  <= lh_p0_d;
      hl_p0_q  <= hl_p0_d;
      hh_p0_q  <= hh_p0_d;
      neg_p0_q <= neg_p0_d;
      tag_p0_q <= tag_p0_d;
      vld_p0_q <= vld_p0_d;
      mid_p1_q <= mid_p1_d;
      ll_p1_q  <= ll_p1_d;
      hh_p1_q  <= hh_p1_d;
      neg_p1_q <= neg_p1_d;
      tag_p1_q <= tag_p1_d;
      vld_p1_q <= vld_p1_d;
      p_p2_q   <= p_p2_d;
      tag_p2_q <= tag_p2_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.p         = p_p2_q;
  assign bus.out_tag   = tag_p2_q;
endmodule
